// File: rtl/ae_pkg.sv
// Shared constants and FSM state type for the 1-to-N word collector.
package ae_pkg;

    localparam int DATA_W  = 16;
    localparam int N_WORDS = 18;
    localparam int IDX_W   = 5;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

endpackage

// File: rtl/idx_counter.sv
// Slot index counter: wraps to 0 after N_WORDS-1, synchronous clear has priority.
module idx_counter #(
    parameter int IDX_W   = 5,
    parameter int N_WORDS = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;

    // Next index: clear, wrap at the last slot, or step by one.
    always_comb begin
        idx_next_s = idx_r;
        if (clr) begin
            idx_next_s = {IDX_W{1'b0}};
        end else if (inc) begin
            if (idx_r == LAST_IDX) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else begin
            idx_r <= idx_next_s;
        end
    end

    assign idx     = idx_r;
    assign at_last = (idx_r == LAST_IDX);

endmodule

// File: rtl/demux_1_18_collector.sv
// Collects N_WORDS stream words into a parallel frame and holds it until acknowledged.
// Optional framing check via in_last/frame_err when DEMUX_LAST_CHECK_EN is defined.
module demux_1_18_collector
    import ae_pkg::state_e;
    import ae_pkg::COLLECT;
    import ae_pkg::FULL;
#(
    parameter int DATA_W  = ae_pkg::DATA_W,
    parameter int N_WORDS = ae_pkg::N_WORDS,
    parameter int IDX_W   = ae_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [N_WORDS*DATA_W-1:0] out_vec,
    output logic [IDX_W-1:0]          word_idx,
    output logic                      frame_valid,
`ifdef DEMUX_LAST_CHECK_EN
    input  logic                      in_last,
    output logic                      frame_err,
`endif
    input  logic                      frame_ack
);

    state_e                      state_r;
    state_e                      state_next_s;
    logic                        in_ready_r;
    logic                        frame_valid_r;
    logic [N_WORDS*DATA_W-1:0]   out_vec_r;
    logic [IDX_W-1:0]            word_idx_s;
    logic                        at_last_s;
    logic                        accept_s;
    logic                        wr_en_s;
    logic                        idx_clr_s;

    assign accept_s = in_valid && (state_r == COLLECT);
    // A flush in the same cycle discards the word outright.
    assign wr_en_s  = accept_s && !flush;

`ifdef DEMUX_LAST_CHECK_EN
    logic early_last_s;
    logic missing_last_s;
    logic frame_err_r;

    assign early_last_s   = wr_en_s && in_last && !at_last_s;
    assign missing_last_s = wr_en_s && !in_last && at_last_s;
    assign idx_clr_s      = flush || early_last_s;

    // Framing error flag: set on a misplaced/missing in_last, cleared on flush or a fresh frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else if (flush) begin
            frame_err_r <= 1'b0;
        end else if (early_last_s || missing_last_s) begin
            frame_err_r <= 1'b1;
        end else if (wr_en_s && (word_idx_s == {IDX_W{1'b0}})) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end

    assign frame_err = frame_err_r;
`else
    assign idx_clr_s = flush;
`endif

    idx_counter #(
        .IDX_W   (IDX_W),
        .N_WORDS (N_WORDS)
    ) u_idx_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (idx_clr_s),
        .inc     (wr_en_s),
        .idx     (word_idx_s),
        .at_last (at_last_s)
    );

    // Next-state logic; flush dominates every other event.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = COLLECT;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s && at_last_s) begin
                        state_next_s = FULL;
                    end else begin
                        state_next_s = COLLECT;
                    end
                end
                FULL: begin
                    if (frame_ack) begin
                        state_next_s = COLLECT;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                default: state_next_s = COLLECT;
            endcase
        end
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= COLLECT;
            in_ready_r    <= 1'b1;
            frame_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            in_ready_r    <= (state_next_s == COLLECT);
            frame_valid_r <= (state_next_s == FULL);
        end
    end

    // Slot registers: only the addressed slot is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vec_r <= {(N_WORDS*DATA_W){1'b0}};
        end else if (wr_en_s) begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (word_idx_s == IDX_W'(k)) begin
                    out_vec_r[k*DATA_W +: DATA_W] <= in_data;
                end
            end
        end else begin
            out_vec_r <= out_vec_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign frame_valid = frame_valid_r;
    assign out_vec     = out_vec_r;
    assign word_idx    = word_idx_s;

endmodule
